ub_port_arbiter: RTL and testbench

Single-port unified-buffer (UB) arbiter for the TPU. It shares the one UB SRAM port between three burst requesters: the host DMA engine, the weight-fetch path (RD_WEIGHT) and the result/activation writeback path. It grants whole bursts in round-robin order, generates the per-beat UB addresses, steers write data, and returns read data with a per-requester valid.

---
 rtl/ub_port_arbiter.sv | 128 ++++++++++++
 tb/tb_ub_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_port_arbiter.sv
// Shares the single unified-buffer SRAM port between DMA, weight fetch and writeback.
// Whole bursts are granted round-robin, with one arbitration bubble after each burst.
module ub_port_arbiter #(
  parameter int DW = 256,
  parameter int AW = 8,
  parameter int LW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*LW-1:0] len,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      ack,
  output logic [2:0]      done,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            ub_en,
  output logic            ub_we,
  output logic [AW-1:0]   ub_addr,
  output logic [DW-1:0]   ub_wdata,
  input  logic [DW-1:0]   ub_rdata,
  output logic            busy,
  output logic [1:0]      owner
);

  // Handshake: a requester holds req (with addr/len/we stable) until its gnt pulse.
  // gnt marks the first beat, ack marks every beat (wdata advances after each),
  // done marks the last beat, and req must be low in the cycle after done.
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]    state;
  logic [1:0]    cur;
  logic [1:0]    last_owner;
  logic [AW-1:0] base;
  logic [LW-1:0] cnt;
  logic [LW-1:0] last_cnt;
  logic          cur_we;
  logic          rd_pend;
  logic [1:0]    rd_owner;

  logic [1:0]    winner;
  logic          win_found;
  logic [1:0]    cand;
  logic [LW-1:0] sel_len;
  logic          last_beat;
  logic [2:0]    cur_onehot;

  function automatic logic [1:0] rr_idx(input logic [1:0] from, input int unsigned offs);
    logic [2:0] s;
    s = {1'b0, from} + 3'(offs);
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Scan from furthest to nearest so the nearest requester after last_owner wins.
  always_comb begin
    win_found = 1'b0;
    winner    = 2'd0;
    cand      = 2'd0;
    for (int j = 3; j >= 1; j--) begin
      cand = rr_idx(last_owner, j);
      if (req[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
    sel_len = len[int'(winner)*LW +: LW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cur        <= 2'd0;
      last_owner <= 2'd2;
      base       <= '0;
      cnt        <= '0;
      last_cnt   <= '0;
      cur_we     <= 1'b0;
      rd_pend    <= 1'b0;
      rd_owner   <= 2'd0;
    end else begin
      rd_pend  <= (state == S_BURST) && !cur_we;
      rd_owner <= cur;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            state    <= S_BURST;
            cur      <= winner;
            base     <= addr[int'(winner)*AW +: AW];
            last_cnt <= (sel_len == '0) ? '0 : sel_len - LW'(1);
            cnt      <= '0;
            cur_we   <= we[winner];
          end
        end
        default: begin
          if (last_beat) begin
            state      <= S_IDLE;
            last_owner <= cur;
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    busy       = (state == S_BURST);
    owner      = busy ? cur : 2'd3;
    cur_onehot = 3'b001 << cur;
    last_beat  = busy && (cnt == last_cnt);
    ack        = busy ? cur_onehot : 3'b000;
    gnt        = (busy && cnt == '0) ? cur_onehot : 3'b000;
    done       = last_beat ? cur_onehot : 3'b000;
    ub_en      = busy;
    ub_we      = busy && cur_we;
    ub_addr    = busy ? base + AW'(cnt) : '0;
    ub_wdata   = (busy && cur_we) ? wdata[int'(cur)*DW +: DW] : '0;
    // rd_owner is registered so read data lands on the right requester even in the bubble.
    rvalid     = rd_pend ? (3'b001 << rd_owner) : 3'b000;
    rdata      = ub_rdata;
  end

endmodule

// File: tb/tb_ub_port_arbiter.sv
// Bench for ub_port_arbiter: directed scenarios plus randomized traffic checked
// against a burst-schedule model and a UB memory model with 1-cycle read latency.
module tb_ub_port_arbiter;
  localparam int DW = 256;
  localparam int AW = 8;
  localparam int LW = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [2:0]      req, we, gnt, ack, done, rvalid;
  logic [3*AW-1:0] addr;
  logic [3*LW-1:0] len;
  logic [3*DW-1:0] wdata;
  logic [DW-1:0]   rdata, ub_wdata, ub_rdata;
  logic            ub_en, ub_we, busy;
  logic [AW-1:0]   ub_addr;
  logic [1:0]      owner;

  ub_port_arbiter #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .len(len), .wdata(wdata),
    .gnt(gnt), .ack(ack), .done(done), .rvalid(rvalid), .rdata(rdata),
    .ub_en(ub_en), .ub_we(ub_we), .ub_addr(ub_addr), .ub_wdata(ub_wdata),
    .ub_rdata(ub_rdata), .busy(busy), .owner(owner)
  );

  // UB SRAM model: capture the access mid-cycle, perform it on the next rising edge.
  logic [DW-1:0] ub_mem [256];
  logic          s_en, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  bit            mem_ready = 1'b0;
  always @(negedge clk) begin
    s_en    <= ub_en;
    s_we    <= ub_we;
    s_addr  <= ub_addr;
    s_wdata <= ub_wdata;
  end
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 256; a++) ub_mem[a] <= DW'(a);
      ub_rdata  <= '0;
      mem_ready <= 1'b1;
    end else if (s_en === 1'b1) begin
      if (s_we) ub_mem[s_addr] <= s_wdata;
      else      ub_rdata <= ub_mem[s_addr];
    end
  end

  // Requester data: each requester presents wbase + (beats already acked).
  logic [DW-1:0] wbase [3];
  int            wcount [3];
  bit            hold [3];
  always_comb begin
    for (int i = 0; i < 3; i++) wdata[i*DW +: DW] = wbase[i] + DW'(wcount[i]);
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: each granted burst is a window of cycles [m_start, m_end].
  int            m_own = -1, m_start = 0, m_end = -10, m_base = 0, m_last = 2;
  int            m_rd_own = -1, m_rd_addr = 0;
  bit            m_we = 1'b0;
  logic [DW-1:0] ref_mem [256];
  logic [24:0]   e_ctl, o_ctl;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [2:0]    e_rvalid;
  assign o_ctl = {gnt, ack, done, rvalid, ub_en, ub_we, ub_addr, busy, owner};

  task automatic model_update();
    int prev, a, k, w, l;
    bit was_busy, found;
    logic [2:0] oh, e_gnt, e_ack, e_done;
    cyc++;
    prev = cyc - 1;
    was_busy = (m_own >= 0) && (prev >= m_start) && (prev <= m_end);
    m_rd_own = -1;
    if (was_busy) begin
      a = (m_base + prev - m_start) % 256;
      if (m_we) ref_mem[a] = wbase[m_own] + DW'(wcount[m_own]);
      else begin
        m_rd_own  = m_own;
        m_rd_addr = a;
      end
      wcount[m_own]++;
      if (prev == m_end) begin
        m_last = m_own;
        m_own  = -1;
      end
    end
    if (rst) begin
      m_own    = -1;
      m_last   = 2;
      m_rd_own = -1;
    end else if (!was_busy) begin
      found = 1'b0;
      for (int j = 1; j <= 3; j++) begin
        w = (m_last + j) % 3;
        if (!found && req[w]) begin
          found   = 1'b1;
          m_own   = w;
          m_start = cyc;
          m_base  = int'(addr[w*AW +: AW]);
          l       = int'(len[w*LW +: LW]);
          m_end   = cyc + ((l == 0) ? 1 : l) - 1;
          m_we    = we[w];
        end
      end
    end
    e_rvalid = (m_rd_own >= 0) ? 3'(1 << m_rd_own) : 3'b000;
    e_rdata  = (m_rd_own >= 0) ? ref_mem[m_rd_addr] : '0;
    if (m_own >= 0 && cyc >= m_start && cyc <= m_end) begin
      k       = cyc - m_start;
      oh      = 3'(1 << m_own);
      e_gnt   = (k == 0) ? oh : 3'b000;
      e_ack   = oh;
      e_done  = (cyc == m_end) ? oh : 3'b000;
      e_ctl   = {e_gnt, e_ack, e_done, e_rvalid, 1'b1, m_we, AW'(m_base + k), 1'b1, 2'(m_own)};
      e_wdata = m_we ? wbase[m_own] + DW'(wcount[m_own]) : '0;
    end else begin
      e_ctl   = {9'b0, e_rvalid, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3};
      e_wdata = '0;
    end
  endtask

  // One clock: model follows the edge, granted requesters drop req, return at negedge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    if (m_own >= 0 && m_start == cyc && !hold[m_own]) req[m_own] = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int a, input int l, input bit w, input logic [DW-1:0] wb);
    addr[i*AW +: AW] = AW'(a);
    len[i*LW +: LW]  = LW'(l);
    we[i]            = w;
    wbase[i]         = wb;
    wcount[i]        = 0;
    req[i]           = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; we = '0; addr = '0; len = '0;
    for (int i = 0; i < 3; i++) begin wbase[i] = '0; wcount[i] = 0; hold[i] = 1'b0; end
    for (int a = 0; a < 256; a++) ref_mem[a] = DW'(a);
    repeat (3) step();
    n_vec++;
    if (o_ctl !== {12'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3}) begin
      n_err++; $display("FAIL reset_ctl got=%h exp=%h", o_ctl, {12'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3});
    end
    n_vec++;
    if (ub_wdata !== '0 || rdata !== '0) begin
      n_err++; $display("FAIL reset_data wdata=%h rdata=%h exp=0", ub_wdata, rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_dma_write();
    logic [24:0] exp;
    set_req(0, 'h10, 4, 1'b1, DW'('hA0));
    for (int k = 0; k < 4; k++) begin
      step();
      exp = {(k == 0) ? 3'b001 : 3'b000, 3'b001, (k == 3) ? 3'b001 : 3'b000, 3'b000,
             1'b1, 1'b1, 8'('h10 + k), 1'b1, 2'd0};
      n_vec++;
      if (o_ctl !== exp) begin n_err++; $display("FAIL dma_ctl beat=%0d got=%h exp=%h", k, o_ctl, exp); end
      n_vec++;
      if (ub_wdata !== DW'('hA0 + k)) begin
        n_err++; $display("FAIL dma_wdata beat=%0d got=%h exp=%h", k, ub_wdata, DW'('hA0 + k));
      end
    end
    step();
    n_vec++;
    if (o_ctl !== {12'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3}) begin
      n_err++; $display("FAIL dma_idle got=%h", o_ctl);
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (ub_mem['h10 + k] !== DW'('hA0 + k)) begin
        n_err++; $display("FAIL dma_mem addr=%0h got=%h exp=%h", 'h10 + k, ub_mem['h10 + k], DW'('hA0 + k));
      end
    end
  endtask

  task automatic test_weight_read();
    set_req(1, 'hFE, 3, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k < 3) begin
        n_vec++;
        if ({ub_en, ub_we, ub_addr, owner, ack} !== {1'b1, 1'b0, 8'(254 + k), 2'd1, 3'b010}) begin
          n_err++; $display("FAIL wread_beat beat=%0d got en=%b we=%b addr=%h owner=%0d exp addr=%h",
                            k, ub_en, ub_we, ub_addr, owner, 8'(254 + k));
        end
      end
      n_vec++;
      if (rvalid !== ((k > 0) ? 3'b010 : 3'b000)) begin
        n_err++; $display("FAIL wread_rvalid cyc=%0d got=%b", k, rvalid);
      end
      if (k > 0) begin
        n_vec++;
        if (rdata !== DW'((253 + k) % 256)) begin
          n_err++; $display("FAIL wread_rdata cyc=%0d got=%h exp=%h", k, rdata, DW'((253 + k) % 256));
        end
      end
    end
  endtask

  task automatic test_contention();
    int own_tab [9] = '{0, 0, 3, 1, 1, 3, 2, 2, 3};
    logic [2:0] exp_ack;
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 'h30, 2, 1'b1, {8{$urandom}});
    set_req(1, 'h40, 2, 1'b0, '0);
    set_req(2, 'h50, 2, 1'b1, {8{$urandom}});
    for (int c = 0; c < 9; c++) begin
      step();
      exp_ack = (own_tab[c] == 3) ? 3'b000 : 3'(1 << own_tab[c]);
      n_vec++;
      if ({owner, ack} !== {2'(own_tab[c]), exp_ack}) begin
        n_err++; $display("FAIL contention cyc=%0d got owner=%0d ack=%b exp owner=%0d ack=%b",
                          c + 1, owner, ack, own_tab[c], exp_ack);
      end
    end
  endtask

  task automatic test_fairness();
    int own_tab [8] = '{0, 3, 1, 3, 0, 3, 1, 3};
    hold[0] = 1'b1;
    hold[1] = 1'b1;
    set_req(0, 'h60, 1, 1'b0, '0);
    set_req(1, 'h61, 1, 1'b0, '0);
    for (int c = 0; c < 8; c++) begin
      step();
      n_vec++;
      if (owner !== 2'(own_tab[c])) begin
        n_err++; $display("FAIL fairness cyc=%0d got owner=%0d exp=%0d", c, owner, own_tab[c]);
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    step();
  endtask

  task automatic test_zero_len();
    set_req(2, 'h70, 0, 1'b1, DW'('h55));
    step();
    n_vec++;
    if (o_ctl !== {3'b100, 3'b100, 3'b100, 3'b000, 1'b1, 1'b1, 8'h70, 1'b1, 2'd2}) begin
      n_err++; $display("FAIL zero_len_ctl got=%h", o_ctl);
    end
    n_vec++;
    if (ub_wdata !== DW'('h55)) begin n_err++; $display("FAIL zero_len_wdata got=%h exp=55", ub_wdata); end
    step();
    n_vec++;
    if ({busy, ub_en, owner} !== {1'b0, 1'b0, 2'd3}) begin
      n_err++; $display("FAIL zero_len_idle got busy=%b en=%b owner=%0d", busy, ub_en, owner);
    end
    n_vec++;
    if (ub_mem['h70] !== DW'('h55)) begin n_err++; $display("FAIL zero_len_mem got=%h exp=55", ub_mem['h70]); end
  endtask

  task automatic test_reset_mid_burst();
    set_req(0, 'h80, 1, 1'b0, '0);
    step();
    step();
    set_req(1, 'h20, 5, 1'b0, '0);
    step();
    step();
    n_vec++;
    if ({owner, ub_addr} !== {2'd1, 8'h21}) begin
      n_err++; $display("FAIL rstmid_beat2 got owner=%0d addr=%h exp owner=1 addr=21", owner, ub_addr);
    end
    rst = 1'b1;
    step();
    n_vec++;
    if ({ub_en, busy, owner, rvalid} !== {1'b0, 1'b0, 2'd3, 3'b000}) begin
      n_err++; $display("FAIL rstmid_idle got en=%b busy=%b owner=%0d rvalid=%b", ub_en, busy, owner, rvalid);
    end
    rst = 1'b0;
    set_req(1, 'h20, 2, 1'b0, '0);
    set_req(0, 'h90, 1, 1'b0, '0);
    step();
    n_vec++;
    if ({owner, gnt} !== {2'd0, 3'b001}) begin
      n_err++; $display("FAIL rstmid_rr got owner=%0d gnt=%b exp owner=0 gnt=001", owner, gnt);
    end
    step();
    step();
    n_vec++;
    if ({owner, gnt} !== {2'd1, 3'b010}) begin
      n_err++; $display("FAIL rstmid_next got owner=%0d gnt=%b exp owner=1 gnt=010", owner, gnt);
    end
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && m_own != i && $urandom_range(0, 2) == 0)
          set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 5)),
                  1'($urandom_range(0, 1)), {8{$urandom}});
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
      n_vec++;
      if (o_ctl !== e_ctl) begin n_err++; $display("FAIL rand_ctl it=%0d got=%h exp=%h", it, o_ctl, e_ctl); end
      n_vec++;
      if (ub_wdata !== e_wdata) begin
        n_err++; $display("FAIL rand_wdata it=%0d got=%h exp=%h", it, ub_wdata, e_wdata);
      end
      if (e_rvalid != 3'b000) begin
        n_vec++;
        if (rdata !== e_rdata) begin n_err++; $display("FAIL rand_rdata it=%0d got=%h exp=%h", it, rdata, e_rdata); end
      end
    end
    rst = 1'b0;
    req = '0;
    repeat (8) step();
    n_vec++;
    if (o_ctl !== {12'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3}) begin
      n_err++; $display("FAIL rand_drain got=%h", o_ctl);
    end
  endtask

  initial begin
    test_reset();
    test_dma_write();
    test_weight_read();
    test_contention();
    test_fairness();
    test_zero_len();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
